// File: rtl/pwm_ramp_ctrl.sv
// Sequencer for a PWM IP: waits for PLL lock, initialises period/duty, then ramps duty toward a target.
// Define PWM_DIRECT_UPDATE_EN to jump straight to the target via duty_cycle/duty_cycle_update instead of ramping.
//
// state      | meaning
// WAIT_LOCK  | PLL not locked, output disabled
// WAIT_CFG   | locked, waiting for cfg_load
// INIT_SET   | initial_cycle/initial_duty_cycle presented to the IP
// INIT_PULSE | initial_update strobe with values held
// INIT_WAIT  | 6-cycle settle before enabling output
// RUN        | output enabled, duty tracks target
module pwm_ramp_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        fclk_lock,
  input  logic [9:0]  cfg_period,
  input  logic [9:0]  cfg_duty,
  input  logic        cfg_load,
  input  logic [9:0]  target_duty,
  input  logic        target_valid,
  input  logic [15:0] step_div,
  output logic        pwm_en,
  output logic [9:0]  initial_cycle,
  output logic [9:0]  initial_duty_cycle,
  output logic        initial_update,
  output logic        up,
  output logic        down,
  output logic [9:0]  duty_cycle,
  output logic        duty_cycle_update,
  output logic [9:0]  cur_duty,
  output logic        busy,
  output logic        at_target
);

  typedef enum logic [2:0] {WAIT_LOCK, WAIT_CFG, INIT_SET, INIT_PULSE, INIT_WAIT, RUN} state_t;

  state_t      state, state_n;
  logic [9:0]  period_n, init_duty_n, cur_n, target, target_n, dc_n;
  logic [9:0]  cfg_clamped, tgt_clamped;
  logic [15:0] div, div_n, step_ld;
  logic [2:0]  wcnt, wcnt_n;
  logic        pwm_en_n, init_upd_n, up_n, down_n, dcu_n, at_target_n;
  logic        pend, pend_n;

  // step_div of 0 behaves as 1, so the divider reload never underflows
  assign step_ld     = (step_div == 16'd0) ? 16'd0 : step_div - 16'd1;
  assign cfg_clamped = (cfg_duty > cfg_period) ? cfg_period : cfg_duty;
  assign tgt_clamped = (target_duty > initial_cycle) ? initial_cycle : target_duty;

  always_comb begin
    state_n     = state;
    period_n    = initial_cycle;
    init_duty_n = initial_duty_cycle;
    cur_n       = cur_duty;
    target_n    = target;
    div_n       = div;
    wcnt_n      = wcnt;
    pwm_en_n    = pwm_en;
    init_upd_n  = 1'b0;
    up_n        = 1'b0;
    down_n      = 1'b0;
    dcu_n       = 1'b0;
    dc_n        = duty_cycle;
    pend_n      = pend;
    if (!fclk_lock) begin
      state_n  = WAIT_LOCK;
      pwm_en_n = 1'b0;
      pend_n   = 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: state_n = WAIT_CFG;
        WAIT_CFG: begin
          if (cfg_load) begin
            period_n    = cfg_period;
            init_duty_n = cfg_clamped;
            state_n     = INIT_SET;
          end
        end
        INIT_SET: begin
          init_upd_n = 1'b1;
          cur_n      = initial_duty_cycle;
          target_n   = initial_duty_cycle;
          state_n    = INIT_PULSE;
        end
        INIT_PULSE: begin
          wcnt_n  = 3'd5;
          state_n = INIT_WAIT;
        end
        INIT_WAIT: begin
          if (wcnt == 3'd0) begin
            pwm_en_n = 1'b1;
            div_n    = step_ld;
            state_n  = RUN;
          end else begin
            wcnt_n = wcnt - 3'd1;
          end
        end
        RUN: begin
          if (cfg_load) begin
            period_n    = cfg_period;
            init_duty_n = cfg_clamped;
            pwm_en_n    = 1'b0;
            pend_n      = 1'b0;
            state_n     = INIT_SET;
          end else begin
            if (target_valid) target_n = tgt_clamped;
`ifdef PWM_DIRECT_UPDATE_EN
            if (pend) begin
              dcu_n  = 1'b1;
              cur_n  = duty_cycle;
              pend_n = 1'b0;
            end else if (target != cur_duty) begin
              dc_n   = target;
              pend_n = 1'b1;
            end
`else
            // target never exceeds period, so stepping toward it cannot wrap
            if (div == 16'd0) begin
              div_n = step_ld;
              if (cur_duty < target) begin
                up_n  = 1'b1;
                cur_n = cur_duty + 10'd1;
              end else if (cur_duty > target) begin
                down_n = 1'b1;
                cur_n  = cur_duty - 10'd1;
              end
            end else begin
              div_n = div - 16'd1;
            end
`endif
          end
        end
        default: state_n = WAIT_LOCK;
      endcase
    end
    at_target_n = (state_n == RUN) && (cur_n == target_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= WAIT_LOCK;
      initial_cycle      <= '0;
      initial_duty_cycle <= '0;
      cur_duty           <= '0;
      target             <= '0;
      div                <= '0;
      wcnt               <= '0;
      pwm_en             <= 1'b0;
      initial_update     <= 1'b0;
      up                 <= 1'b0;
      down               <= 1'b0;
      duty_cycle         <= '0;
      duty_cycle_update  <= 1'b0;
      pend               <= 1'b0;
      busy               <= 1'b0;
      at_target          <= 1'b0;
    end else begin
      state              <= state_n;
      initial_cycle      <= period_n;
      initial_duty_cycle <= init_duty_n;
      cur_duty           <= cur_n;
      target             <= target_n;
      div                <= div_n;
      wcnt               <= wcnt_n;
      pwm_en             <= pwm_en_n;
      initial_update     <= init_upd_n;
      up                 <= up_n;
      down               <= down_n;
      duty_cycle         <= dc_n;
      duty_cycle_update  <= dcu_n;
      pend               <= pend_n;
      busy               <= !at_target_n;
      at_target          <= at_target_n;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: directed stimulus pushes expected pulses, a negedge monitor pops them.
module tb_pwm_ramp_ctrl;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst, fclk_lock, cfg_load, target_valid;
  logic [9:0]  cfg_period, cfg_duty, target_duty;
  logic [15:0] step_div;
  logic        pwm_en, initial_update, up, down, duty_cycle_update, busy, at_target;
  logic [9:0]  initial_cycle, initial_duty_cycle, duty_cycle, cur_duty;

  typedef struct packed {
    logic [1:0] kind;   // 0 init, 1 up, 2 down, 3 direct update
    logic [9:0] a;
    logic [9:0] b;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc_n = 0;
  int         last_step = -1;
  logic [9:0] prev_dc = '0;

  pwm_ramp_ctrl dut (
    .clk(clk), .rst(rst), .fclk_lock(fclk_lock),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_load(cfg_load),
    .target_duty(target_duty), .target_valid(target_valid), .step_div(step_div),
    .pwm_en(pwm_en), .initial_cycle(initial_cycle), .initial_duty_cycle(initial_duty_cycle),
    .initial_update(initial_update), .up(up), .down(down),
    .duty_cycle(duty_cycle), .duty_cycle_update(duty_cycle_update),
    .cur_duty(cur_duty), .busy(busy), .at_target(at_target)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input logic [9:0] a, input logic [9:0] b);
    exp_t e;
    e.kind = k; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic push_ramp(input int from, input int to);
    if (to > from) for (int v = from + 1; v <= to; v++) push(2'd1, 10'(v), 10'd0);
    else           for (int v = from - 1; v >= to; v--) push(2'd2, 10'(v), 10'd0);
  endtask

  task automatic pulse_target(input logic [9:0] v);
    target_duty = v; target_valid = 1'b1;
    tick(1);
    target_valid = 1'b0;
  endtask

  task automatic do_cfg(input logic [9:0] p, input logic [9:0] d);
    cfg_period = p; cfg_duty = d; cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
  endtask

  task automatic wait_cur(input logic [9:0] v, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (cur_duty == v) break;
    end
    chk(name, cur_duty, v);
  endtask

  task automatic wait_at_target(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (at_target) break;
    end
    chk(name, at_target, 1);
  endtask

  task automatic wait_pwm(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (pwm_en) break;
    end
    chk(name, pwm_en, 1);
  endtask

  // monitor: every strobe from the DUT must match the head of the expected queue
  always @(negedge clk) begin
    logic [1:0] k;
    logic [9:0] ga, gb;
    exp_t       e;
    if (!rst) begin
      if (up && down) begin
        n_tests++; n_fail++;
        $display("FAIL up_down_overlap got=1 want=0 cycle=%0d", cyc_n);
      end
      if (initial_update || up || down || duty_cycle_update) begin
        if (initial_update)    begin k = 2'd0; ga = initial_cycle; gb = initial_duty_cycle; last_step = -1; end
        else if (up)           begin k = 2'd1; ga = cur_duty; gb = 10'd0; end
        else if (down)         begin k = 2'd2; ga = cur_duty; gb = 10'd0; end
        else                   begin k = 2'd3; ga = duty_cycle; gb = prev_dc; end
        if ((up || down) && last_step >= 0) begin
          n_tests++;
          if ((cyc_n - last_step) < STEP || ((cyc_n - last_step) % STEP) != 0) begin
            n_fail++;
            $display("FAIL step_spacing got=%0d want=multiple_of_%0d", cyc_n - last_step, STEP);
          end
        end
        if (up || down) last_step = cyc_n;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse got=kind%0d/%0h/%0h want=none", k, ga, gb);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || e.a != ga || e.b != gb) begin
            n_fail++;
            $display("FAIL pulse got=kind%0d/%0h/%0h want=kind%0d/%0h/%0h", k, ga, gb, e.kind, e.a, e.b);
          end
        end
      end
    end
    prev_dc = duty_cycle;
  end

  initial begin
    rst = 1'b1; fclk_lock = 1'b0; cfg_load = 1'b0; target_valid = 1'b0;
    cfg_period = '0; cfg_duty = '0; target_duty = '0; step_div = 16'(STEP);
    tick(3);
    chk("rst_pwm_en", pwm_en, 0);
    chk("rst_cur_duty", cur_duty, 0);
    chk("rst_busy", busy, 0);
    chk("rst_initial_cycle", initial_cycle, 0);
    rst = 1'b0;
    tick(2);
    chk("wait_lock_busy", busy, 1);
    chk("wait_lock_pwm_en", pwm_en, 0);

    fclk_lock = 1'b1;
    tick(1);
    push(2'd0, 10'h100, 10'h010);
    do_cfg(10'h100, 10'h010);
    chk("init_set_cycle", initial_cycle, 10'h100);
    chk("init_set_duty", initial_duty_cycle, 10'h010);
    chk("init_set_no_update", initial_update, 0);
    tick(1);
    chk("init_pulse_update", initial_update, 1);
    tick(6);
    chk("init_wait_pwm_off", pwm_en, 0);
    tick(1);
    chk("run_pwm_on", pwm_en, 1);
    chk("run_cur_duty", cur_duty, 10'h010);
    chk("run_at_target", at_target, 1);
    chk("run_busy", busy, 0);

`ifdef PWM_DIRECT_UPDATE_EN
    push(2'd3, 10'h020, 10'h020);
    pulse_target(10'h020);
    chk("direct_busy", busy, 1);
    wait_at_target(20, "direct_at_target");
    chk("direct_cur_duty", cur_duty, 10'h020);
    tick(10);
`else
    push_ramp(16'h10, 16'h13);
    pulse_target(10'h013);
    chk("ramp_busy", busy, 1);
    wait_at_target(40, "ramp13_at_target");
    chk("ramp13_cur_duty", cur_duty, 10'h013);
    chk("ramp13_busy", busy, 0);

    push_ramp(16'h13, 16'h18);
    pulse_target(10'h020);
    wait_cur(10'h018, 60, "ramp20_midway");
    push_ramp(16'h18, 16'h08);
    pulse_target(10'h008);
    wait_at_target(120, "redirect_at_target");
    chk("redirect_cur_duty", cur_duty, 10'h008);

    push_ramp(16'h08, 16'h100);
    pulse_target(10'h3FF);
    wait_at_target(1200, "sat_at_target");
    chk("sat_cur_duty", cur_duty, 10'h100);
    tick(12);
    chk("sat_hold", cur_duty, 10'h100);

    push(2'd0, 10'h080, 10'h080);
    cfg_period = 10'h080; cfg_duty = 10'h200; target_duty = 10'h010;
    cfg_load = 1'b1; target_valid = 1'b1;
    tick(1);
    cfg_load = 1'b0; target_valid = 1'b0;
    chk("reinit_pwm_off", pwm_en, 0);
    chk("reinit_period", initial_cycle, 10'h080);
    chk("reinit_duty_clamp", initial_duty_cycle, 10'h080);
    wait_pwm(20, "reinit_pwm_on");
    chk("reinit_cur_duty", cur_duty, 10'h080);
    chk("reinit_target_discarded", at_target, 1);

    push_ramp(16'h80, 16'h7C);
    pulse_target(10'h000);
    wait_cur(10'h07C, 40, "lockdrop_midway");
    fclk_lock = 1'b0;
    tick(1);
    chk("lockdrop_pwm_off", pwm_en, 0);
    chk("lockdrop_at_target", at_target, 0);
    chk("lockdrop_busy", busy, 1);
    tick(8);
    chk("lockdrop_cur_hold", cur_duty, 10'h07C);

    fclk_lock = 1'b1;
    tick(1);
    push(2'd0, 10'h100, 10'h020);
    do_cfg(10'h100, 10'h020);
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("rst_mid_init_pwm_en", pwm_en, 0);
    chk("rst_mid_init_cycle", initial_cycle, 0);
    chk("rst_mid_init_duty", initial_duty_cycle, 0);
    chk("rst_mid_init_cur", cur_duty, 0);
    chk("rst_mid_init_at_target", at_target, 0);
    rst = 1'b0;
    tick(12);
    chk("post_rst_pwm_off", pwm_en, 0);
`endif

    chk("queue_empty", 16'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
